// File: rtl/rom_segment_cache.sv
// Single-word ROM segment cache: answers hits combinationally and refills one
// 32-bit SDRAM word through a req/ack/valid handshake with the arbiter.
//
// state  | meaning
// S_IDLE | serve hits from the cached word, launch a refill on a read miss
// S_REQ  | ctrl_req high, ctrl_addr held at req_tag, waiting for ctrl_ack
// S_WAIT | request accepted, waiting for ctrl_valid to deliver the word
module rom_segment_cache #(
  parameter int          ROM_ADDR_WIDTH = 16,
  parameter int          ROM_DATA_WIDTH = 8,
  parameter logic [23:0] ROM_OFFSET     = 24'h0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cs,
  input  logic                      oe,
  input  logic                      flush,
  input  logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  output logic [ROM_DATA_WIDTH-1:0] rom_data,
  output logic [22:0]               ctrl_addr,
  output logic                      ctrl_req,
  input  logic                      ctrl_ack,
  input  logic                      ctrl_valid,
  output logic                      ctrl_hit,
  input  logic [31:0]               ctrl_data
);

  localparam int          SHIFT     = (ROM_DATA_WIDTH == 8) ? 2 : (ROM_DATA_WIDTH == 16) ? 1 : 0;
  localparam logic [1:0]  LANE_MASK = 2'((1 << SHIFT) - 1);
  localparam logic [22:0] BASE      = {1'b0, ROM_OFFSET[23:2]};

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t                    state, state_nxt;
  logic [31:0]               cache_data;
  logic [ROM_ADDR_WIDTH-1:0] cache_tag;
  logic                      cache_vld;
  logic [ROM_ADDR_WIDTH-1:0] req_tag;
  logic                      flush_pend;
  logic [ROM_ADDR_WIDTH-1:0] word_idx;
  logic [1:0]                lane;
  logic                      start;
  logic                      fill;
  logic                      bypass;

  function automatic logic [22:0] map_addr(input logic [ROM_ADDR_WIDTH-1:0] idx);
    return BASE + 23'(idx);
  endfunction

  function automatic logic [ROM_DATA_WIDTH-1:0] pick_lane(input logic [31:0] word,
                                                          input logic [1:0]  sel);
    logic [31:0] shifted;
    shifted = word >> (int'(sel) * ROM_DATA_WIDTH);
    return shifted[ROM_DATA_WIDTH-1:0];
  endfunction

  assign word_idx = rom_addr >> SHIFT;
  assign lane     = rom_addr[1:0] & LANE_MASK;
  assign ctrl_hit = cs & cache_vld & (cache_tag == word_idx) & ~flush;
  assign start    = (state == S_IDLE) & cs & oe & ~ctrl_hit;
  assign fill     = ((state == S_REQ) & ctrl_ack & ctrl_valid) | ((state == S_WAIT) & ctrl_valid);
  assign bypass   = (state == S_WAIT) & ctrl_valid & (req_tag == word_idx);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_REQ;
      S_REQ:   if (ctrl_ack) state_nxt = ctrl_valid ? S_IDLE : S_WAIT;
      S_WAIT:  if (ctrl_valid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl_req  = (state == S_REQ);
    ctrl_addr = map_addr((state == S_IDLE) ? word_idx : req_tag);
    rom_data  = pick_lane(bypass ? ctrl_data : cache_data, lane);
  end

  // A flush seen while a refill is in flight poisons that refill, so stale
  // pre-download data never becomes valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cache_data <= '0;
      cache_tag  <= '0;
      cache_vld  <= 1'b0;
      req_tag    <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (start) req_tag <= word_idx;
      if (fill) begin
        if (!(flush_pend || flush)) begin
          cache_data <= ctrl_data;
          cache_tag  <= req_tag;
          cache_vld  <= 1'b1;
        end else begin
          cache_vld <= 1'b0;
        end
        flush_pend <= 1'b0;
      end else if (flush) begin
        cache_vld <= 1'b0;
        if (state != S_IDLE) flush_pend <= 1'b1;
      end
    end
  end

endmodule
